// File: rtl/divrem_sequencer.sv
// Multi-cycle radix-2 restoring divide/remainder unit (RISC-V M semantics, XLEN=64).
// It accepts one request in IDLE and holds the result in DONE until EX/MEM takes it.
module divrem_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_word,
  input  logic [63:0] req_rs1,
  input  logic [63:0] req_rs2,
  input  logic [5:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_result,
  output logic [5:0]  resp_rd,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PREP, BUSY, FIX, DONE} state_t;

  state_t      state, nxt;
  logic [1:0]  op_q;
  logic        word_q, qneg_q, rneg_q;
  logic [5:0]  rd_q;
  logic [63:0] a_q, b_q, dvs_q, quo_q, rem_q;
  logic [6:0]  cnt;

  logic        accept, signed_op, a_neg, b_neg, div_zero, ovf, special, ge;
  logic [63:0] rs1_ext, rs2_ext, a_mag, b_mag, q_fix, r_fix, sel, result;
  logic [64:0] rem_sh, diff;

  assign accept    = (state == IDLE) && req_valid && !flush;
  assign rs1_ext   = !req_word ? req_rs1 : req_op[0] ? {32'b0, req_rs1[31:0]} : {{32{req_rs1[31]}}, req_rs1[31:0]};
  assign rs2_ext   = !req_word ? req_rs2 : req_op[0] ? {32'b0, req_rs2[31:0]} : {{32{req_rs2[31]}}, req_rs2[31:0]};

  assign signed_op = ~op_q[0];
  assign a_neg     = signed_op & a_q[63];
  assign b_neg     = signed_op & b_q[63];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;
  assign div_zero  = (b_q == 64'd0);
  assign ovf       = signed_op && (b_q == '1) &&
                     (a_q == (word_q ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  assign special   = div_zero | ovf;

  // 65-bit shifted remainder so the compare never loses the carried-out bit
  assign rem_sh    = {rem_q, quo_q[63]};
  assign diff      = rem_sh - {1'b0, dvs_q};
  assign ge        = (rem_sh >= {1'b0, dvs_q});

  assign q_fix     = qneg_q ? -quo_q : quo_q;
  assign r_fix     = rneg_q ? -rem_q : rem_q;
  assign sel       = op_q[1] ? r_fix : q_fix;
  assign result    = word_q ? {{32{sel[31]}}, sel[31:0]} : sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Special cases skip BUSY but still pass through FIX for selection and word extension
  always_comb begin
    nxt = state;
    if (flush) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (req_valid) nxt = PREP;
        PREP:    nxt = special ? FIX : BUSY;
        BUSY:    if (cnt == 7'd1) nxt = FIX;
        FIX:     nxt = DONE;
        DONE:    if (resp_ready) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= '0; word_q <= 1'b0; rd_q <= '0; a_q <= '0; b_q <= '0;
      dvs_q <= '0; quo_q <= '0; rem_q <= '0; cnt <= '0;
      qneg_q <= 1'b0; rneg_q <= 1'b0;
    end else if (accept) begin
      op_q <= req_op; word_q <= req_word; rd_q <= req_rd;
      a_q  <= rs1_ext; b_q <= rs2_ext;
    end else if (!flush) begin
      case (state)
        PREP: begin
          cnt    <= word_q ? 7'd32 : 7'd64;
          qneg_q <= !special && (a_neg ^ b_neg);
          rneg_q <= !special && a_neg;
          dvs_q  <= b_mag;
          if (div_zero) begin
            quo_q <= '1;  rem_q <= a_q;
          end else if (ovf) begin
            quo_q <= a_q; rem_q <= '0;
          end else begin
            rem_q <= '0;
            // word dividend starts at the top so 32 shifts leave the quotient in [31:0]
            quo_q <= word_q ? {a_mag[31:0], 32'b0} : a_mag;
          end
        end
        BUSY: begin
          cnt   <= cnt - 7'd1;
          rem_q <= ge ? diff[63:0] : rem_sh[63:0];
          quo_q <= {quo_q[62:0], ge};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0; resp_result <= '0; resp_rd <= '0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else if (state == FIX) begin
      resp_valid  <= 1'b1;
      resp_result <= result;
      resp_rd     <= rd_q;
    end else if (state == DONE && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_divrem_sequencer.sv
// Bench for divrem_sequencer: directed RISC-V M cases, random ops against an
// arithmetic reference model, back-pressure, back-to-back, flush and async reset.
module tb_divrem_sequencer;
  logic        clk = 1'b0, reset, req_valid, req_ready, req_word, flush;
  logic        resp_valid, resp_ready, busy;
  logic [1:0]  req_op;
  logic [63:0] req_rs1, req_rs2, resp_result;
  logic [5:0]  req_rd, resp_rd;
  int checks = 0, passes = 0;

  divrem_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_word(req_word), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd(req_rd), .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_rd(resp_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    longint sa, sb; int sa32, sb32; logic [31:0] r32; logic [63:0] r;
    if (w) begin
      sa32 = a[31:0]; sb32 = b[31:0];
      if (b[31:0] == 32'd0) r32 = op[1] ? a[31:0] : 32'hFFFF_FFFF;
      else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : a[31:0];
      else case (op)
        2'd0: r32 = sa32 / sb32;
        2'd1: r32 = a[31:0] / b[31:0];
        2'd2: r32 = sa32 % sb32;
        default: r32 = a[31:0] % b[31:0];
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa = a; sb = b;
    if (b == 64'd0) r = op[1] ? a : '1;
    else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) r = op[1] ? 64'd0 : a;
    else case (op)
      2'd0: r = sa / sb;
      2'd1: r = a / b;
      2'd2: r = sa % sb;
      default: r = a % b;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [1:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    if (w) begin
      if (b[31:0] == 32'd0 || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 2;
      return 34;
    end
    if (b == 64'd0 || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1)) return 2;
    return 66;
  endfunction

  task automatic drive(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] rd);
    req_op = op; req_word = w; req_rs1 = a; req_rs2 = b; req_rd = rd;
  endtask

  // Issue one op, time it from the accepting edge, optionally stall DONE for 'hold' cycles
  task automatic do_op(input string name, input logic [1:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [5:0] rd,
                       input logic [63:0] exp, input int lat, input int hold);
    int cyc;
    @(negedge clk); drive(op, w, a, b, rd); req_valid = 1'b1;
    checks++; if (req_ready !== 1'b1) $display("FAIL %s req_ready got %b want 1", name, req_ready); else passes++;
    @(posedge clk); #1; req_valid = 1'b0; cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc !== lat) $display("FAIL %s latency got %0d want %0d", name, cyc, lat); else passes++;
    checks++; if (resp_result !== exp) $display("FAIL %s result got %h want %h", name, resp_result, exp); else passes++;
    checks++; if (resp_rd !== rd) $display("FAIL %s rd got %0d want %0d", name, resp_rd, rd); else passes++;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== exp || resp_rd !== rd || busy !== 1'b1)
        $display("FAIL %s hold%0d valid=%b res=%h rd=%0d busy=%b want 1 %h %0d 1",
                 name, i, resp_valid, resp_result, resp_rd, busy, exp, rd);
      else passes++;
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL %s handshake valid=%b ready=%b want 0 1", name, resp_valid, req_ready);
    else passes++;
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_result !== 64'd0 || resp_rd !== 6'd0)
      $display("FAIL reset ready=%b busy=%b valid=%b res=%h rd=%0d want 1 0 0 0 0",
               req_ready, busy, resp_valid, resp_result, resp_rd);
    else passes++;
  endtask

  task automatic test_directed();
    do_op("div100_m7",  2'd0, 1'b0, 64'd100, -64'sd7, 6'd1, 64'hFFFF_FFFF_FFFF_FFF2, 66, 0);
    do_op("rem100_m7",  2'd2, 1'b0, 64'd100, -64'sd7, 6'd2, 64'd2, 66, 0);
    do_op("rem_m100_7", 2'd2, 1'b0, -64'sd100, 64'd7, 6'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    do_op("divu_by0",   2'd1, 1'b0, 64'd5, 64'd0, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    do_op("remu_by0",   2'd3, 1'b0, 64'd5, 64'd0, 6'd5, 64'd5, 2, 0);
    do_op("div_ovf",    2'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 6'd6, 64'h8000_0000_0000_0000, 2, 0);
    do_op("rem_ovf",    2'd2, 1'b0, 64'h8000_0000_0000_0000, '1, 6'd7, 64'd0, 2, 0);
    do_op("divw_ovf",   2'd0, 1'b1, 64'h0000_0000_8000_0000, '1, 6'd8, 64'hFFFF_FFFF_8000_0000, 2, 0);
    do_op("divuw",      2'd1, 1'b1, 64'h0000_1234_FFFF_FFFF, 64'd1, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
    do_op("remw_m7_2",  2'd2, 1'b1, -64'sd7, 64'd2, 6'd10, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
  endtask

  task automatic test_random();
    logic [63:0] a, b; logic [1:0] op; logic w; logic [5:0] rd;
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3)); w = 1'($urandom_range(0, 1)); rd = 6'($urandom);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      case ($urandom_range(0, 5))
        0: b = 64'd0;
        1: b = '1;
        2: b = 64'($urandom_range(1, 20));
        3: b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      do_op($sformatf("rand%0d", n), op, w, a, b, rd, model(op, w, a, b), latency(op, w, a, b), 0);
    end
  endtask

  task automatic test_backpressure();
    do_op("bp_divu", 2'd1, 1'b0, 64'd1000, 64'd7, 6'd33, 64'd142, 66, 5);
  endtask

  task automatic test_back_to_back();
    int cyc;
    resp_ready = 1'b1;
    @(negedge clk); drive(2'd1, 1'b0, 64'd77, 64'd7, 6'd11); req_valid = 1'b1;
    @(posedge clk); #1; drive(2'd3, 1'b0, 64'd80, 64'd7, 6'd12); cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc !== 66 || resp_result !== 64'd11) $display("FAIL b2b_first lat=%0d res=%h want 66 %h", cyc, resp_result, 64'd11); else passes++;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL b2b_handshake valid=%b ready=%b want 0 1", resp_valid, req_ready); else passes++;
    @(posedge clk); #1; req_valid = 1'b0; cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc !== 66 || resp_result !== 64'd3 || resp_rd !== 6'd12) $display("FAIL b2b_second lat=%0d res=%h rd=%0d want 66 %h 12", cyc, resp_result, resp_rd, 64'd3); else passes++;
    @(negedge clk); resp_ready = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk); drive(2'd0, 1'b0, 64'd12345, 64'd17, 6'd20); req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    checks++; if (busy !== 1'b1) $display("FAIL flush_pre busy got %b want 1", busy); else passes++;
    @(posedge clk); #1; flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL flush_idle ready=%b busy=%b valid=%b want 1 0 0", req_ready, busy, resp_valid);
    else passes++;
    do_op("post_flush", 2'd1, 1'b0, 64'd50, 64'd6, 6'd21, 64'd8, 66, 0);
  endtask

  task automatic test_async_reset();
    do_op("pre_rst", 2'd1, 1'b0, 64'd100, 64'd3, 6'd5, 64'd33, 66, 0);
    @(negedge clk); drive(2'd0, 1'b0, 64'd999, 64'd4, 6'd40); req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #2; reset = 1'b0; #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_result !== 64'd0 || resp_rd !== 6'd0)
      $display("FAIL async_reset ready=%b busy=%b valid=%b res=%h rd=%0d want 1 0 0 0 0",
               req_ready, busy, resp_valid, resp_result, resp_rd);
    else passes++;
    @(negedge clk); reset = 1'b1;
    do_op("post_rst", 2'd1, 1'b0, 64'd9, 64'd3, 6'd41, 64'd3, 66, 0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    drive(2'd0, 1'b0, 64'd0, 64'd0, 6'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
